// File: rtl/breath_led_array.sv
// Multi-channel breathing-LED driver: one shared PWM frame counter feeds CH
// independent triangular duty ramps with per-channel mode control.
module breath_led_array #(
  parameter int unsigned CNT_NUM    = 3464,
  parameter int unsigned W          = 12,
  parameter int unsigned CH         = 4,
  parameter int unsigned ACTIVE_LOW = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [2*CH-1:0] mode,
  output logic [CH-1:0]   led,
  output logic [W*CH-1:0] level,
  output logic [CH-1:0]   peak,
  output logic            frame
);

  localparam logic [W-1:0]  TOP      = W'(CNT_NUM - 1);
  localparam logic [1:0]    MODE_OFF = 2'b00;
  localparam logic [1:0]    MODE_ON  = 2'b01;
  localparam logic [CH-1:0] UNLIT    = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [W-1:0]  cnt_q, cnt_n;
  logic [W-1:0]  d_q [CH];
  logic [W-1:0]  d_n [CH];
  logic [1:0]    mq_q [CH];
  logic [1:0]    mq_n [CH];
  logic [CH-1:0] dir_q, dir_n;
  logic [CH-1:0] lit, led_n, peak_n;
  logic          frame_end;

  // Next-state: frame counter, per-channel reinit / ramp step, lit decision
  always_comb begin
    frame_end = en && (cnt_q == TOP);
    cnt_n     = cnt_q;
    if (en) cnt_n = frame_end ? '0 : cnt_q + W'(1);
    for (int i = 0; i < CH; i++) begin
      d_n[i]    = d_q[i];
      dir_n[i]  = dir_q[i];
      mq_n[i]   = mq_q[i];
      peak_n[i] = 1'b0;
      case (mq_q[i])
        MODE_OFF: lit[i] = 1'b0;
        MODE_ON:  lit[i] = en;
        default:  lit[i] = en && (cnt_q < d_q[i]);
      endcase
      led_n[i] = (ACTIVE_LOW != 0) ? ~lit[i] : lit[i];
      // Mode change wins over the frame-end step; bit 0 selects the bright start
      if (mode[2*i +: 2] != mq_q[i]) begin
        mq_n[i]  = mode[2*i +: 2];
        d_n[i]   = mode[2*i] ? TOP : '0;
        dir_n[i] = mode[2*i];
      end else if (frame_end && mq_q[i][1]) begin
        if (!dir_q[i]) begin
          if (d_q[i] < TOP) begin
            d_n[i] = d_q[i] + W'(1);
          end else begin
            dir_n[i]  = 1'b1;
            peak_n[i] = 1'b1;
          end
        end else begin
          if (d_q[i] != '0) d_n[i] = d_q[i] - W'(1);
          else              dir_n[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      dir_q <= '0;
      led   <= UNLIT;
      peak  <= '0;
      frame <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        d_q[i]  <= '0;
        mq_q[i] <= MODE_OFF;
      end
    end else begin
      cnt_q <= cnt_n;
      dir_q <= dir_n;
      led   <= led_n;
      peak  <= peak_n;
      frame <= frame_end;
      for (int i = 0; i < CH; i++) begin
        d_q[i]  <= d_n[i];
        mq_q[i] <= mq_n[i];
      end
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_level
    assign level[W*g +: W] = d_q[g];
  end

endmodule

// File: doc/breath_led_array.md
# breath_led_array

Multi-channel successor to the single breathing-LED driver: one shared PWM frame counter drives CH independent duty-cycle ramps. Each channel has its own mode (off, on, breathe, breathe anti-phase), a level readback, and a peak pulse. It sits between the board LED pins and control logic (key scanner or mode FSM) that selects per-channel modes.

## Interface
- CNT_NUM, 3464: PWM frame length in clocks and number of brightness levels; legal range 2..2^W−1.
- W, 12: width of the frame counter and of each duty register.
- CH, 4: number of LED channels.
- ACTIVE_LOW, 1: 1 = LED lit when output is 0 (board default); 0 = lit when output is 1.

- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global run enable.
- mode  in  2*CH  per-channel mode, channel i at [2i+1:2i]: 00 off, 01 on, 10 breathe (starts dark), 11 breathe anti-phase (starts bright).
- led  out  CH  registered LED drive, polarity per ACTIVE_LOW.
- level  out  W*CH  current duty d[i] of channel i at [W*i+W−1:W*i].
- peak  out  CH  one-cycle pulse when channel i turns from rising to falling.
- frame  out  1  one-cycle pulse on the last clock of each PWM frame.

## Operation
- Frame counter cnt: 0..CNT_NUM−1, +1 per clock while en=1, wraps to 0 after CNT_NUM−1. Holds while en=0.
- Frame end: en=1 and cnt==CNT_NUM−1.
- Per channel: duty d (W bits) and direction dir (0 up, 1 down). Registered mode_q tracks mode.
- Mode change (mode[i] != mode_q[i]) reinitialises on that clock edge and overrides frame-end updates:
  - 00: d=0, dir=0.
  - 01: d=CNT_NUM−1, dir=1.
  - 10: d=0, dir=0.
  - 11: d=CNT_NUM−1, dir=1.
  - mode_q updated on the same edge. Reinit applies even when en=0.
- Breathe modes (10/11), frame end, no mode change:
  - dir=0, d<CNT_NUM−1: d+1.
  - dir=0, d==CNT_NUM−1: dir←1, d holds, peak[i]=1 for that cycle.
  - dir=1, d>0: d−1.
  - dir=1, d==0: dir←0, d holds.
- Modes 00/01: d frozen after reinit.
- Lit condition (en=1): mode 00 never; mode 01 always; modes 10/11 when cnt<d. With d=0, never lit; with d=CNT_NUM−1, dark 1 clock per frame.
- led[i] = ACTIVE_LOW ? ~lit : lit, registered. en=0 forces unlit.
- One full breathe cycle = 2·CNT_NUM frames = 2·CNT_NUM² clocks (default ≈ 24.0 M clocks = 2 s at 12 MHz).
- Arithmetic is unsigned W-bit. d never leaves 0..CNT_NUM−1 and never wraps.

## Timing
- Reset (rst=1 at edge): cnt=0, every d=0, dir=0, mode_q=00. led = all unlit (all 1s when ACTIVE_LOW=1). peak=0, frame=0, level=0. Reset overrides en and mode.
- First edge after reset with mode≠00 is a mode change, so reinit occurs then.
- led latency: 1 clock. led at edge t+1 reflects cnt, d, mode_q, and en sampled at edge t.
- frame and peak are registered. They are high in the clock after the frame-end edge, for exactly 1 cycle.
- level shows d directly and changes on the frame-end edge or the reinit edge.
- en falling: cnt, d, and dir freeze; led goes unlit 1 clock later. en rising: resumes from the frozen cnt with no skipped or repeated count.
- Simultaneous frame end and mode change: the mode change wins; no peak is generated.

## Test plan
- CNT_NUM=4, CH=2, mode=10/10, en=1 after reset -> level per frame 0,1,2,3,3,2,1,0,0,1…; cycle length 32 clocks; peak once per cycle, on the frame where level first holds at 3.
- Same config, frame with d=2 -> led[0] (ACTIVE_LOW) low for 2 clocks and high for 2 clocks, delayed 1 clock from cnt; frame pulse every 4 clocks.
- Channel 0 in mode 10, channel 1 in mode 11 -> level1 = 3 − level0 on every frame after reinit.
- Modes 00 and 01 -> led constant 1 and 0 respectively; level 0 and 3; peak never asserted.
- Drop en for 7 clocks mid-ramp -> cnt and level frozen, led all 1; after en returns, ramp resumes from the same cnt and level.
- Assert rst mid-ramp with level=2 -> next clock: level 0, led all 1, peak 0, frame 0; reinit on the first clock after rst deasserts.
